i2c_init_sequencer: RTL and testbench

- Parametrised I2C register-initialisation sequencer: walks an external init table of {reg, data} entries and issues one I2C write per entry through a request/response handshake to the team's I2C master.
- Retries NACKed writes, executes in-table delay entries, and re-runs the whole table on a restart pulse (e.g. HDMI hot-plug).
- Sits between the top-level HDMI bring-up logic and the I2C controller; runs on the system clock.

---
 rtl/i2c_init_pkg.sv | 35 +++
 rtl/i2c_init_delay_timer.sv | 52 +++++
 rtl/i2c_init_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_i2c_init_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_init_pkg.sv
// Shared types and constants for the I2C register-initialisation sequencer.
// Optional build macro I2C_INIT_READBACK_VERIFY_EN adds the read-back verify states.
package i2c_init_pkg;

  // State encoding is exported unchanged on state_out.
  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_FETCH        = 4'd1,
    ST_DECODE       = 4'd2,
    ST_DELAY        = 4'd3,
    ST_ISSUE        = 4'd4,
    ST_WAIT_RSP     = 4'd5,
    ST_NEXT         = 4'd6,
    ST_DONE         = 4'd7,
    ST_FAIL         = 4'd8
`ifdef I2C_INIT_READBACK_VERIFY_EN
    ,
    ST_VERIFY_ISSUE = 4'd9,
    ST_VERIFY_WAIT  = 4'd10
`endif
  } state_t;

  // Table word layout: {reg[15:8], data[7:0]}.
  localparam int TBL_REG_MSB  = 15;
  localparam int TBL_REG_LSB  = 8;
  localparam int TBL_DATA_MSB = 7;
  localparam int TBL_DATA_LSB = 0;

  // Register value that turns a table entry into a delay of data * DELAY_UNIT cycles.
  localparam logic [7:0] DEFAULT_DELAY_MARKER = 8'hFF;

  // Retry counter width; covers MAX_RETRIES up to 15.
  localparam int RETRY_W = 4;

endpackage

// File: rtl/i2c_init_delay_timer.sv
// Delay timer: load a unit count, then expire after count * UNIT cycles.
// A count of zero expires in the first cycle after the load.
// The expired output is high during the final counted cycle, so a caller that
// leaves its wait state on expired spends exactly count * UNIT cycles there.
module i2c_init_delay_timer #(
  parameter int UNIT  = 50000,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam int              TICK_W    = (UNIT > 1) ? $clog2(UNIT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UNIT - 1);

  logic [CNT_W-1:0]  units;
  logic [TICK_W-1:0] tick;
  logic              active;

  // Expire on the last tick of the last unit, or at once for a zero count.
  always_comb begin
    expired = active && ((units == '0) ||
                         ((units == CNT_W'(1)) && (tick == TICK_LAST)));
  end

  // Unit/tick down-counter; clear and reset abandon a running delay.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      active <= 1'b0;
      units  <= '0;
      tick   <= '0;
    end else if (load) begin
      active <= 1'b1;
      units  <= count;
      tick   <= '0;
    end else if (active) begin
      if (expired) begin
        active <= 1'b0;
      end else if (tick == TICK_LAST) begin
        tick  <= '0;
        units <= units - 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_init_sequencer.sv
// I2C register-initialisation sequencer: walks an external {reg, data} table and
// issues one I2C write per entry, with NACK retries, delay entries and restart.
// Optional build macro I2C_INIT_READBACK_VERIFY_EN adds a read-back check of
// every written register (ports req_rd / rsp_rdata).
//
// Request handshake: req_valid rises only in an issue state and stays high with
// req_reg/req_data/req_rd unchanged until the cycle where req_valid && req_ready,
// which is the acceptance; exactly one request is then outstanding until the
// single-cycle rsp_valid pulse, which is ignored in every other state.
module i2c_init_sequencer
  import i2c_init_pkg::*;
#(
  parameter int         NUM_ENTRIES  = 31,
  parameter logic [7:0] DEV_ADDR     = 8'h72,
  parameter int         MAX_RETRIES  = 3,
  parameter logic [7:0] DELAY_MARKER = DEFAULT_DELAY_MARKER,
  parameter int         DELAY_UNIT   = 50000,
  parameter int         IDX_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [15:0]      tbl_data,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [7:0]       req_dev,
  output logic [7:0]       req_reg,
  output logic [7:0]       req_data,
  input  logic             rsp_valid,
  input  logic             rsp_nack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_idx,
`ifdef I2C_INIT_READBACK_VERIFY_EN
  output logic             req_rd,
  input  logic [7:0]       rsp_rdata,
`endif
  output logic [3:0]       state_out
);

  state_t               state, state_d;
  logic [IDX_W-1:0]     idx;
  logic [RETRY_W-1:0]   retry;
  logic [7:0]           entry_reg, entry_data;
  logic                 restart_pending;
  logic                 timer_expired;

  // Control strobes from the next-state logic to the datapath registers.
  logic restart, latch_entry, inc_idx, inc_retry, clr_retry;
  logic set_done, set_error, set_pending, timer_load;
  logic can_retry;

  assign can_retry = (retry < RETRY_W'(MAX_RETRIES));
  assign tbl_idx   = idx;
  assign req_dev   = DEV_ADDR;
  assign req_reg   = entry_reg;
  assign req_data  = entry_data;
  assign state_out = state;
  assign busy      = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL));

  i2c_init_delay_timer #(
    .UNIT  (DELAY_UNIT),
    .CNT_W (8)
  ) u_delay_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .clear   (restart),
    .count   (tbl_data[TBL_DATA_MSB:TBL_DATA_LSB]),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Next-state, request outputs and datapath strobes.
  always_comb begin
    state_d     = state;
    req_valid   = 1'b0;
`ifdef I2C_INIT_READBACK_VERIFY_EN
    req_rd      = 1'b0;
`endif
    restart     = 1'b0;
    latch_entry = 1'b0;
    inc_idx     = 1'b0;
    inc_retry   = 1'b0;
    clr_retry   = 1'b0;
    set_done    = 1'b0;
    set_error   = 1'b0;
    set_pending = 1'b0;
    timer_load  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          restart = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (start) begin
          restart = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (start) begin
          restart = 1'b1;
          state_d = ST_FETCH;
        end else begin
          latch_entry = 1'b1;
          if (tbl_data[TBL_REG_MSB:TBL_REG_LSB] == DELAY_MARKER) begin
            timer_load = 1'b1;
            state_d    = ST_DELAY;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DELAY: begin
        if (start) begin
          restart = 1'b1;
          state_d = ST_FETCH;
        end else if (timer_expired) begin
          state_d = ST_NEXT;
        end
      end
      // A start here cannot withdraw the request; it is remembered instead.
      ST_ISSUE: begin
        req_valid   = 1'b1;
        set_pending = start;
        if (req_ready) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        set_pending = start;
        if (rsp_valid) begin
          if (restart_pending || start) begin
            restart = 1'b1;
            state_d = ST_FETCH;
          end else if (!rsp_nack) begin
`ifdef I2C_INIT_READBACK_VERIFY_EN
            state_d = ST_VERIFY_ISSUE;
`else
            state_d = ST_NEXT;
`endif
          end else if (can_retry) begin
            inc_retry = 1'b1;
            state_d   = ST_ISSUE;
          end else begin
            set_error = 1'b1;
            state_d   = ST_FAIL;
          end
        end
      end
`ifdef I2C_INIT_READBACK_VERIFY_EN
      ST_VERIFY_ISSUE: begin
        req_valid   = 1'b1;
        req_rd      = 1'b1;
        set_pending = start;
        if (req_ready) state_d = ST_VERIFY_WAIT;
      end
      // A NACKed or mismatching read costs one attempt and retries from the write.
      ST_VERIFY_WAIT: begin
        set_pending = start;
        if (rsp_valid) begin
          if (restart_pending || start) begin
            restart = 1'b1;
            state_d = ST_FETCH;
          end else if (!rsp_nack && (rsp_rdata == entry_data)) begin
            state_d = ST_NEXT;
          end else if (can_retry) begin
            inc_retry = 1'b1;
            state_d   = ST_ISSUE;
          end else begin
            set_error = 1'b1;
            state_d   = ST_FAIL;
          end
        end
      end
`endif
      ST_NEXT: begin
        if (start) begin
          restart = 1'b1;
          state_d = ST_FETCH;
        end else begin
          clr_retry = 1'b1;
          if (idx == IDX_W'(NUM_ENTRIES - 1)) begin
            set_done = 1'b1;
            state_d  = ST_DONE;
          end else begin
            inc_idx = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Index, retry, entry latch and sticky status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx             <= '0;
      retry           <= '0;
      entry_reg       <= '0;
      entry_data      <= '0;
      done            <= 1'b0;
      error           <= 1'b0;
      err_idx         <= '0;
      restart_pending <= 1'b0;
    end else begin
      if (restart) begin
        idx             <= '0;
        retry           <= '0;
        done            <= 1'b0;
        error           <= 1'b0;
        err_idx         <= '0;
        restart_pending <= 1'b0;
      end else begin
        if (set_pending) restart_pending <= 1'b1;
        if (inc_idx)     idx <= idx + 1'b1;
        if (clr_retry)      retry <= '0;
        else if (inc_retry) retry <= retry + 1'b1;
        if (set_done) done <= 1'b1;
        if (set_error) begin
          error   <= 1'b1;
          err_idx <= idx;
        end
      end
      if (latch_entry) begin
        entry_reg  <= tbl_data[TBL_REG_MSB:TBL_REG_LSB];
        entry_data <= tbl_data[TBL_DATA_MSB:TBL_DATA_LSB];
      end
    end
  end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer with a small I2C master responder model
// and a registered table ROM. Build with I2C_INIT_READBACK_VERIFY_EN to cover
// the read-back verify variant.
module tb_i2c_init_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  tbl_idx;
  logic [15:0] tbl_data;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_dev;
  logic [7:0]  req_reg;
  logic [7:0]  req_data;
  logic        rsp_valid;
  logic        rsp_nack;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  err_idx;
  logic [3:0]  state_out;
`ifdef I2C_INIT_READBACK_VERIFY_EN
  logic        req_rd;
  logic [7:0]  rsp_rdata;
  localparam int STEP = 2;   // logged transactions per successful entry
`else
  localparam int STEP = 1;
`endif

  i2c_init_sequencer #(
    .NUM_ENTRIES  (5),
    .DEV_ADDR     (8'h72),
    .MAX_RETRIES  (3),
    .DELAY_MARKER (8'hFF),
    .DELAY_UNIT   (10),
    .IDX_W        (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .tbl_idx   (tbl_idx),
    .tbl_data  (tbl_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dev   (req_dev),
    .req_reg   (req_reg),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_nack  (rsp_nack),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_idx   (err_idx),
`ifdef I2C_INIT_READBACK_VERIFY_EN
    .req_rd    (req_rd),
    .rsp_rdata (rsp_rdata),
`endif
    .state_out (state_out)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- table ROM: data valid one cycle after the index ----------------
  logic [15:0] rom [0:7];
  always @(posedge clk) tbl_data <= rom[tbl_idx[2:0]];

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];       // {rd, reg, data}
  logic [16:0] got_q[$];
  int          req_cyc_q[$];   // cycle each logged request was accepted
  int          rsp_cyc_q[$];   // cycle its response was driven
  int          vec_cnt  = 0;
  int          miss_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- I2C master responder ----------------
  logic        hold_ready = 1'b0;
  logic [15:0] nack_word  = 16'h0000;
  int          nack_n     = 0;          // remaining NACKs, -1 = forever
  logic [15:0] bad_word   = 16'h0000;
  int          bad_n      = 0;          // remaining corrupted read-backs
  logic [7:0]  regmem [0:255];

  initial begin
    logic        rd;
    logic        nk;
    logic [7:0]  rdat;
    logic [15:0] w;
    for (int i = 0; i < 256; i++) regmem[i] = 8'h00;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
`ifdef I2C_INIT_READBACK_VERIFY_EN
    rsp_rdata = 8'h00;
`endif
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      req_ready = !hold_ready;
      if (!reset && req_valid && req_ready) begin
        rd = 1'b0;
`ifdef I2C_INIT_READBACK_VERIFY_EN
        rd = req_rd;
`endif
        w = {req_reg, req_data};
        got_q.push_back({rd, w});
        req_cyc_q.push_back(cyc);
        check("req_dev", {24'd0, req_dev}, 32'h72);
        nk   = 1'b0;
        rdat = regmem[req_reg];
        if (!rd) begin
          if (w == nack_word && nack_n != 0) begin
            nk = 1'b1;
            if (nack_n > 0) nack_n--;
          end else begin
            regmem[req_reg] = req_data;
          end
        end else if (w == bad_word && bad_n > 0) begin
          rdat = 8'h31;
          bad_n--;
        end
        repeat (2) @(negedge clk);
        rsp_valid = 1'b1;
        rsp_nack  = nk;
`ifdef I2C_INIT_READBACK_VERIFY_EN
        rsp_rdata = rdat;
`endif
        rsp_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic load_table(input logic [15:0] e0, e1, e2, e3, e4);
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3; rom[4] = e4;
    rom[5] = 16'h0; rom[6] = 16'h0; rom[7] = 16'h0;
  endtask

  // Expected write only (NACKed attempt or response discarded).
  task automatic exp_w(input logic [15:0] w);
    exp_q.push_back({1'b0, w});
  endtask

  // Expected successful entry: the write plus, when enabled, its read-back.
  task automatic exp_wr(input logic [15:0] w);
    exp_q.push_back({1'b0, w});
`ifdef I2C_INIT_READBACK_VERIFY_EN
    exp_q.push_back({1'b1, w});
`endif
  endtask

  task automatic clear_logs();
    exp_q.delete(); got_q.delete(); req_cyc_q.delete(); rsp_cyc_q.delete();
  endtask

  task automatic cmp_log(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_req%0d", tag, i), {15'd0, got_q[i]}, {15'd0, exp_q[i]});
    clear_logs();
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic [3:0] st);
    check({tag, "_done"},  {31'd0, done},  {31'd0, d});
    check({tag, "_error"}, {31'd0, error}, {31'd0, e});
    check({tag, "_busy"},  {31'd0, busy},  32'd0);
    check({tag, "_state"}, {28'd0, state_out}, {28'd0, st});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int stable;
    int i1;
    int i2;
    reset = 1'b1;
    start = 1'b0;
    load_table(16'h9803, 16'h1630, 16'h1846, 16'hFF00, 16'hFF00);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset values.
    check("rst_state",  {28'd0, state_out}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_error",  {31'd0, error}, 32'd0);
    check("rst_valid",  {31'd0, req_valid}, 32'd0);
    check("rst_dev",    {24'd0, req_dev}, 32'h72);
    check("rst_reg",    {24'd0, req_reg}, 32'd0);
    check("rst_data",   {24'd0, req_data}, 32'd0);
    check("rst_idx",    {24'd0, tbl_idx}, 32'd0);
    check("rst_erridx", {24'd0, err_idx}, 32'd0);

    // All ACK: three writes in table order, delay entries issue nothing.
    clear_logs();
    exp_wr(16'h9803); exp_wr(16'h1630); exp_wr(16'h1846);
    pulse_start();
    check("ack_busy", {31'd0, busy}, 32'd1);
    wait_idle("ack");
    cmp_log("ack");
    check_status("ack", 1'b1, 1'b0, 4'd7);

    // Entry 1 NACKs twice: three write attempts for 16/30, then success.
    nack_word = 16'h1630; nack_n = 2;
    exp_wr(16'h9803); exp_w(16'h1630); exp_w(16'h1630); exp_wr(16'h1630); exp_wr(16'h1846);
    pulse_start();
    check("retry_done_clr", {31'd0, done}, 32'd0);
    wait_idle("retry");
    cmp_log("retry");
    check_status("retry", 1'b1, 1'b0, 4'd7);

    // Entry 2 NACKs forever: first attempt plus three retries, then FAIL.
    nack_word = 16'h1846; nack_n = -1;
    exp_wr(16'h9803); exp_wr(16'h1630);
    exp_w(16'h1846); exp_w(16'h1846); exp_w(16'h1846); exp_w(16'h1846);
    pulse_start();
    wait_idle("fail");
    cmp_log("fail");
    check_status("fail", 1'b0, 1'b1, 4'd8);
    check("fail_erridx", {24'd0, err_idx}, 32'd2);

    // Restart from FAIL clears the status and reruns from index 0.
    nack_n = 0;
    exp_wr(16'h9803); exp_wr(16'h1630); exp_wr(16'h1846);
    pulse_start();
    check("rerun_state", {28'd0, state_out}, 32'd1);
    check("rerun_error", {31'd0, error}, 32'd0);
    check("rerun_erridx", {24'd0, err_idx}, 32'd0);
    wait_idle("rerun");
    cmp_log("rerun");
    check_status("rerun", 1'b1, 1'b0, 4'd7);

    // Delay entries with DELAY_UNIT = 10. From the response of the previous
    // entry the walk is NEXT, FETCH, DECODE, DELAY (5 * 10 = 50 cycles), NEXT,
    // FETCH, DECODE, ISSUE: the request is seen 57 cycles after the response
    // is driven. FF00 spends a single DELAY cycle: 8 cycles.
    load_table(16'h9803, 16'hFF05, 16'h1630, 16'hFF00, 16'h1846);
    exp_wr(16'h9803); exp_wr(16'h1630); exp_wr(16'h1846);
    pulse_start();
    wait_idle("delay");
    i1 = STEP;
    i2 = 2 * STEP;
    if (got_q.size() > i2 && rsp_cyc_q.size() > i2) begin
      check("delay5_gap", req_cyc_q[i1] - rsp_cyc_q[i1-1], 32'd57);
      check("delay0_gap", req_cyc_q[i2] - rsp_cyc_q[i2-1], 32'd8);
    end
    cmp_log("delay");
    check_status("delay", 1'b1, 1'b0, 4'd7);

    // Back-pressure on entry 1, start pulsed while the request is pending.
    load_table(16'h9803, 16'h1630, 16'h1846, 16'hFF00, 16'hFF00);
    exp_wr(16'h9803); exp_w(16'h1630);
    exp_wr(16'h9803); exp_wr(16'h1630); exp_wr(16'h1846);
    pulse_start();
    n = 0;
    while (got_q.size() < STEP && n < 200) begin
      @(negedge clk);
      n++;
    end
    hold_ready = 1'b1;
    n = 0;
    while (!(req_valid && req_reg == 8'h16) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hold_reach", {23'd0, req_valid, req_reg}, {23'd0, 1'b1, 8'h16});
    stable = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_valid !== 1'b1 || req_reg !== 8'h16 || req_data !== 8'h30) stable++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      if (req_valid !== 1'b1 || req_reg !== 8'h16 || req_data !== 8'h30) stable++;
      @(negedge clk);
    end
    check("hold_stable", stable, 32'd0);
    check("hold_state", {28'd0, state_out}, 32'd4);
    hold_ready = 1'b0;
    wait_idle("hold");
    cmp_log("hold");
    check_status("hold", 1'b1, 1'b0, 4'd7);

`ifdef I2C_INIT_READBACK_VERIFY_EN
    // Read-back of 16/30 returns 0x31 once: write, read, write, read, advance.
    bad_word = 16'h1630; bad_n = 1;
    exp_wr(16'h9803); exp_wr(16'h1630); exp_wr(16'h1630); exp_wr(16'h1846);
    pulse_start();
    wait_idle("verify");
    cmp_log("verify");
    check_status("verify", 1'b1, 1'b0, 4'd7);
`endif

    // Reset mid-sequence returns to IDLE; the late response is ignored.
    pulse_start();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_state", {28'd0, state_out}, 32'd0);
    check("midrst_valid", {31'd0, req_valid}, 32'd0);
    repeat (10) @(negedge clk);
    check("midrst_idle", {28'd0, state_out}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    clear_logs();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  // Global time bound in case a wait loop is ever defeated.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

endmodule
